// File: rtl/nonce_scheduler.sv
// Nonce issue sequencer for the pipelined SHA-256 double-hash datapath.
// Optional MINER_HASHCNT_EN adds a saturating count of accepted results (hash_count).
module nonce_scheduler #(
  parameter int WORD_S  = 32,
  parameter int H_SIZE  = 256,
  parameter int LATENCY = 130,
  parameter int CNT_W   = 48
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_S-1:0] nonce_start,
  input  logic [WORD_S-1:0] nonce_end,
  input  logic [WORD_S-1:0] target,
  output logic              pipe_en,
  output logic [WORD_S-1:0] pipe_nonce,
  input  logic              res_valid,
  input  logic [WORD_S-1:0] res_nonce,
  input  logic [H_SIZE-1:0] res_hash,
  output logic              busy,
  output logic              done,
  output logic              found,
  output logic [WORD_S-1:0] found_nonce
`ifdef MINER_HASHCNT_EN
  ,
  output logic [CNT_W-1:0]  hash_count
`endif
);

  localparam int IF_W = $clog2(LATENCY + 2);
  localparam logic [WORD_S-1:0] NONCE_ONE = {{(WORD_S-1){1'b0}}, 1'b1};
  localparam logic [IF_W-1:0]   IF_ONE    = {{(IF_W-1){1'b0}}, 1'b1};
  localparam logic [IF_W-1:0]   IF_ZERO   = {IF_W{1'b0}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state_r, state_next_s;
  logic [WORD_S-1:0] cur_r, cur_next_s;
  logic [WORD_S-1:0] end_r;
  logic [WORD_S-1:0] target_r;
  logic              pipe_en_r;
  logic [WORD_S-1:0] pipe_nonce_r;
  logic              busy_r, done_r, found_r;
  logic [WORD_S-1:0] found_nonce_r;
  logic [IF_W-1:0]   inflight_r;

  logic              load_s, issue_s;
  logic [WORD_S-1:0] issue_nonce_s;
  logic              res_accept_s, below_s, hit_s;

  // Results with nothing in flight are stale and must not count or hit.
  assign res_accept_s = res_valid && (inflight_r != IF_ZERO);
  assign below_s      = res_hash[H_SIZE-1 -: WORD_S] < target_r;
  assign hit_s        = res_accept_s && below_s && !found_r;

  assign pipe_en     = pipe_en_r;
  assign pipe_nonce  = pipe_nonce_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign found       = found_r;
  assign found_nonce = found_nonce_r;

  // Next-state and issue decision.
  always_comb begin
    state_next_s  = state_r;
    cur_next_s    = cur_r;
    load_s        = 1'b0;
    issue_s       = 1'b0;
    issue_nonce_s = cur_r;
    case (state_r)
      IDLE, DONE: begin
        if (start) begin
          load_s        = 1'b1;
          issue_s       = 1'b1;
          issue_nonce_s = nonce_start;
          cur_next_s    = nonce_start + NONCE_ONE;
          if (nonce_start == nonce_end) begin
            state_next_s = DRAIN;
          end else begin
            state_next_s = ISSUE;
          end
        end else begin
          state_next_s = state_r;
        end
      end
      ISSUE: begin
        if (abort || hit_s) begin
          state_next_s = DRAIN;
        end else begin
          issue_s       = 1'b1;
          issue_nonce_s = cur_r;
          cur_next_s    = cur_r + NONCE_ONE;
          if (cur_r == end_r) begin
            state_next_s = DRAIN;
          end else begin
            state_next_s = ISSUE;
          end
        end
      end
      DRAIN: begin
        // The last registered issue is not yet in the in-flight count.
        if ((inflight_r == IF_ZERO) && !res_valid && !pipe_en_r) begin
          state_next_s = DONE;
        end else begin
          state_next_s = DRAIN;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Control state, job registers and issue outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      cur_r        <= {WORD_S{1'b0}};
      end_r        <= {WORD_S{1'b0}};
      target_r     <= {WORD_S{1'b0}};
      pipe_en_r    <= 1'b0;
      pipe_nonce_r <= {WORD_S{1'b0}};
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      cur_r     <= cur_next_s;
      pipe_en_r <= issue_s;
      busy_r    <= (state_next_s == ISSUE) || (state_next_s == DRAIN);
      done_r    <= (state_r == DRAIN) && (state_next_s == DONE);
      if (load_s) begin
        end_r    <= nonce_end;
        target_r <= target;
      end
      if (issue_s) begin
        pipe_nonce_r <= issue_nonce_s;
      end
    end
  end

  // First-hit capture and in-flight tracking.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      found_r       <= 1'b0;
      found_nonce_r <= {WORD_S{1'b0}};
      inflight_r    <= IF_ZERO;
    end else begin
      if (load_s) begin
        found_r       <= 1'b0;
        found_nonce_r <= {WORD_S{1'b0}};
      end else if (hit_s) begin
        found_r       <= 1'b1;
        found_nonce_r <= res_nonce;
      end
      case ({pipe_en_r, res_accept_s})
        2'b10:   inflight_r <= inflight_r + IF_ONE;
        2'b01:   inflight_r <= inflight_r - IF_ONE;
        default: inflight_r <= inflight_r;
      endcase
    end
  end

`ifdef MINER_HASHCNT_EN
  logic [CNT_W-1:0] hash_count_r;
  assign hash_count = hash_count_r;

  // Saturating count of accepted results for the current job.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hash_count_r <= {CNT_W{1'b0}};
    end else if (load_s) begin
      hash_count_r <= {CNT_W{1'b0}};
    end else if (res_accept_s && !(&hash_count_r)) begin
      hash_count_r <= hash_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end
`else
  localparam int UNUSED_CNT_W = CNT_W;
`endif

  // Only the top word of the hash takes part in the target compare.
  logic unused_hash_s;
  assign unused_hash_s = ^res_hash[H_SIZE-WORD_S-1:0];

endmodule

// File: tb/tb_nonce_scheduler.sv
// Directed bench for nonce_scheduler with a fixed-latency pipeline model.
module tb_nonce_scheduler;
  localparam int WORD_S  = 32;
  localparam int H_SIZE  = 256;
  localparam int LATENCY = 130;
  localparam int CNT_W   = 48;

  logic              clk = 1'b0;
  logic              reset, start, abort;
  logic [WORD_S-1:0] nonce_start, nonce_end, target;
  logic              pipe_en;
  logic [WORD_S-1:0] pipe_nonce;
  logic              res_valid;
  logic [WORD_S-1:0] res_nonce;
  logic [H_SIZE-1:0] res_hash;
  logic              busy, done, found;
  logic [WORD_S-1:0] found_nonce;
`ifdef MINER_HASHCNT_EN
  logic [CNT_W-1:0]  hash_count;
`endif

  nonce_scheduler #(.WORD_S(WORD_S), .H_SIZE(H_SIZE), .LATENCY(LATENCY), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .nonce_start(nonce_start), .nonce_end(nonce_end), .target(target),
    .pipe_en(pipe_en), .pipe_nonce(pipe_nonce),
    .res_valid(res_valid), .res_nonce(res_nonce), .res_hash(res_hash),
    .busy(busy), .done(done), .found(found), .found_nonce(found_nonce)
`ifdef MINER_HASHCNT_EN
    , .hash_count(hash_count)
`endif
  );

  always #5 clk = ~clk;

  // Pipeline model: a nonce accepted in cycle t returns as a result in cycle t+LATENCY.
  int                hit_mode = 0;
  logic [LATENCY-1:0] pv;
  logic [WORD_S-1:0] pn [LATENCY];

  function automatic logic [WORD_S-1:0] model_top(input logic [WORD_S-1:0] n, input int mode);
    case (mode)
      1:       return (n == 32'd37) ? 32'h0000_0005 : 32'hFFFF_FFFF;
      2:       return (n == 32'd3 || n == 32'd5) ? 32'h0000_0005 : 32'hFFFF_FFFF;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      pv <= '0;
      for (int i = 0; i < LATENCY; i++) pn[i] <= '0;
    end else begin
      pv    <= {pv[LATENCY-2:0], pipe_en};
      pn[0] <= pipe_nonce;
      for (int i = 1; i < LATENCY; i++) pn[i] <= pn[i-1];
    end
  end

  assign res_valid = pv[LATENCY-1];
  assign res_nonce = pn[LATENCY-1];
  assign res_hash  = {model_top(res_nonce, hit_mode), {(H_SIZE-WORD_S){1'b0}}};

  // Monitor: logs issues, results, hits and done pulses with their cycle numbers.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [WORD_S-1:0] iss_n [$];
  int                iss_c [$];
  int                hit_c [$];
  int                res_total = 0;
  int                done_total = 0;

  always @(negedge clk) begin
    if (pipe_en) begin
      iss_n.push_back(pipe_nonce);
      iss_c.push_back(cyc);
    end
    if (res_valid) res_total++;
    if (res_valid && (res_hash[H_SIZE-1 -: WORD_S] < target)) hit_c.push_back(cyc);
    if (done) done_total++;
  end

  int n_cmp = 0;
  int n_bad = 0;
  int ib, rb, db, hb, st_cyc, res_at_done;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic start_job(input logic [WORD_S-1:0] s, input logic [WORD_S-1:0] e,
                           input logic [WORD_S-1:0] t, input int mode);
    tick(1);
    hit_mode    = mode;
    nonce_start = s;
    nonce_end   = e;
    target      = t;
    ib = iss_n.size();
    rb = res_total;
    db = done_total;
    hb = hit_c.size();
    st_cyc = cyc;
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int bound);
    int i;
    i = 0;
    while (done_total == db && i < bound) begin
      tick(1);
      i++;
    end
    res_at_done = res_total - rb;
    tick(3);
    check_eq(tag, 64'(done_total - db), 64'd1);
  endtask

  int n_iss;

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    nonce_start = '0; nonce_end = '0; target = '0;
    tick(3);
    check_eq("rst_pipe_en", 64'(pipe_en), 64'd0);
    check_eq("rst_pipe_nonce", 64'(pipe_nonce), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_found", 64'(found), 64'd0);
    check_eq("rst_found_nonce", 64'(found_nonce), 64'd0);
    reset = 1'b0;
    tick(2);

    // Basic range, no hits.
    start_job(32'h10, 32'h13, 32'h0, 0);
    wait_done("j1_done", 1000);
    n_iss = iss_n.size() - ib;
    check_eq("j1_issues", 64'(n_iss), 64'd4);
    for (int k = 0; k < 4; k++) check_eq("j1_nonce", 64'(iss_n[ib+k]), 64'(32'h10 + k));
    check_eq("j1_first_cyc", 64'(iss_c[ib] - st_cyc), 64'd1);
    check_eq("j1_consecutive", 64'(iss_c[ib+3] - iss_c[ib]), 64'd3);
    check_eq("j1_res_at_done", 64'(res_at_done), 64'd4);
    check_eq("j1_found", 64'(found), 64'd0);
    check_eq("j1_busy", 64'(busy), 64'd0);
`ifdef MINER_HASHCNT_EN
    check_eq("j1_hash_count", 64'(hash_count), 64'd4);
`endif

    // Wrapping range.
    start_job(32'hFFFF_FFFE, 32'h0000_0001, 32'h0, 0);
    wait_done("j2_done", 1000);
    check_eq("j2_issues", 64'(iss_n.size() - ib), 64'd4);
    check_eq("j2_n0", 64'(iss_n[ib]),   64'h0000_0000_FFFF_FFFE);
    check_eq("j2_n1", 64'(iss_n[ib+1]), 64'h0000_0000_FFFF_FFFF);
    check_eq("j2_n2", 64'(iss_n[ib+2]), 64'h0);
    check_eq("j2_n3", 64'(iss_n[ib+3]), 64'h1);
    check_eq("j2_results", 64'(res_at_done), 64'd4);

    // Single hit at nonce 37 stops issuing early.
    start_job(32'd0, 32'd999, 32'h10, 1);
    wait_done("j3_done", 3000);
    n_iss = iss_n.size() - ib;
    check_eq("j3_found", 64'(found), 64'd1);
    check_eq("j3_found_nonce", 64'(found_nonce), 64'd37);
    check_eq("j3_hit_seen", 64'(hit_c.size() > hb), 64'd1);
    if (hit_c.size() > hb) begin
      check_eq("j3_stop_after_hit", 64'(iss_c[iss_c.size()-1] <= hit_c[hb] + 1), 64'd1);
    end
    check_eq("j3_drained", 64'(res_at_done), 64'(n_iss));
    check_eq("j3_early_stop", 64'(n_iss < 1000), 64'd1);

    // Two hits: the first wins.
    start_job(32'd0, 32'd20, 32'h10, 2);
    wait_done("j4_done", 1000);
    check_eq("j4_found", 64'(found), 64'd1);
    check_eq("j4_found_nonce", 64'(found_nonce), 64'd3);

    // Abort five cycles in; a start during drain is ignored.
    start_job(32'd0, 32'd1000, 32'h0, 0);
    tick(5);
    abort = 1'b1;
    begin
      int ab_cyc;
      ab_cyc = cyc;
      tick(1);
      abort = 1'b0;
      tick(20);
      nonce_start = 32'd500;
      nonce_end   = 32'd600;
      start = 1'b1;
      tick(1);
      start = 1'b0;
      check_eq("j5_busy_drain", 64'(busy), 64'd1);
      wait_done("j5_done", 1000);
      n_iss = iss_n.size() - ib;
      check_eq("j5_issue_bound", 64'(n_iss >= 1 && n_iss <= 6), 64'd1);
      check_eq("j5_no_issue_after_abort", 64'(iss_c[iss_c.size()-1] <= ab_cyc), 64'd1);
      check_eq("j5_drained", 64'(res_at_done), 64'(n_iss));
      check_eq("j5_found", 64'(found), 64'd0);
    end

    // Asynchronous reset in the middle of issuing.
    start_job(32'd0, 32'd999, 32'h10, 1);
    tick(10);
    #2;
    reset = 1'b1;
    #1;
    check_eq("ar_pipe_en", 64'(pipe_en), 64'd0);
    check_eq("ar_pipe_nonce", 64'(pipe_nonce), 64'd0);
    check_eq("ar_busy", 64'(busy), 64'd0);
    check_eq("ar_done", 64'(done), 64'd0);
    tick(2);
    reset = 1'b0;
    tick(2);

    // Full 1000-nonce job after reset.
    start_job(32'd0, 32'd999, 32'h0, 0);
    wait_done("j6_done", 3000);
    check_eq("j6_issues", 64'(iss_n.size() - ib), 64'd1000);
    check_eq("j6_last_nonce", 64'(iss_n[iss_n.size()-1]), 64'd999);
    check_eq("j6_results", 64'(res_at_done), 64'd1000);
    check_eq("j6_found", 64'(found), 64'd0);
`ifdef MINER_HASHCNT_EN
    check_eq("j6_hash_count", 64'(hash_count), 64'd1000);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/nonce_scheduler.md
Name: nonce_scheduler

Overview:
- Sequences the pipelined SHA-256 double-hash datapath for mining.
- Issues one nonce per cycle into the pipeline over a programmed range and tracks in-flight work.
- Compares each returned hash's most-significant word against a target and latches the first winning nonce.
- Sits between the AXI/register front end and the hashing pipeline.

Parameters:
WORD_S, 32, nonce and target word width
H_SIZE, 256, hash width returned by the pipeline
LATENCY, 130, pipeline depth in cycles (issue to result); sizes the in-flight counter
CNT_W, 48, width of the optional hash counter

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse; loads range/target, begins issuing
abort  in  1  one-cycle pulse; stops issuing, drains pipeline
nonce_start  in  WORD_S  first nonce (inclusive)
nonce_end  in  WORD_S  last nonce (inclusive)
target  in  WORD_S  hit when hash[H_SIZE-1 -: WORD_S] < target (unsigned)
pipe_en  out  1  pipeline enable; one nonce accepted per asserted cycle
pipe_nonce  out  WORD_S  nonce presented with pipe_en
res_valid  in  1  pipeline result strobe (en_next)
res_nonce  in  WORD_S  nonce accompanying result
res_hash  in  H_SIZE  result hash
busy  out  1  high in ISSUE or DRAIN
done  out  1  one-cycle pulse on entering DONE
found  out  1  sticky; a hit was seen in the current job
found_nonce  out  WORD_S  nonce of first hit

Behaviour:
- Reset (async, active-high): state=IDLE; pipe_en=0, pipe_nonce=0, busy=0, done=0, found=0, found_nonce=0, in-flight=0.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE/DONE + start: latch nonce_end and target; cur=nonce_start; clear found/found_nonce; go ISSUE.
- start while busy is ignored.
- ISSUE:
  - pipe_en=1 and pipe_nonce=cur every cycle, registered; the first issue occurs the cycle after start.
  - cur increments modulo 2^WORD_S.
  - After issuing cur==nonce_end, go DRAIN.
  - nonce_end<nonce_start wraps through 0xFFFFFFFF to 0.
  - nonce_start==nonce_end issues exactly one nonce.
- DRAIN: pipe_en=0; when in-flight==0 and no res_valid pending, go DONE.
- DONE: done pulses for 1 cycle; stays in DONE; found/found_nonce hold until the next start.
- In-flight counter, width clog2(LATENCY+2):
  - +1 per issue, −1 per res_valid.
  - Simultaneous issue and result: unchanged.
  - res_valid at zero in-flight is ignored and does not underflow.
- Hit check: combinational compare on res_valid.
  - First hit sets found=1 and found_nonce=res_nonce, registered, visible the cycle after res_valid.
  - Later hits are ignored.
- First hit while in ISSUE: stop issuing next cycle and go DRAIN.
  - A nonce issued on the same cycle still counts in-flight.
- abort in ISSUE: go DRAIN next cycle, no further issues.
- abort in IDLE/DONE/DRAIN: no effect.
- abort and start in the same cycle: abort wins if busy; otherwise start.
- Full range (start=0, end=0xFFFFFFFF): 2^32 issues and no deadlock; completion is determined by the cur==nonce_end compare, not by a count.

Optional Feature:
- MINER_HASHCNT_EN defined:
  - Adds output hash_count[CNT_W-1:0], which counts res_valid results accepted since the last start.
  - Cleared on start and on reset; saturates at all-ones.
- Undefined: no port and no counter logic.

Test Plan:
- Range 0x10..0x13, target=0, LATENCY model 130 → pipe_en high 4 consecutive cycles with nonces 0x10,0x11,0x12,0x13; done pulses after the 4th result; found=0.
- Range 0xFFFFFFFE..0x00000001 → issues FFFFFFFE, FFFFFFFF, 0, 1, then drains; exactly 4 results.
- Range 0..999; model returns hash top word 0x00000005 for nonce 37, else 0xFFFFFFFF; target=0x10 → found=1 with found_nonce=37; issuing stops ≤1 cycle after the hit; done only after in-flight reaches 0.
- Hits at nonces 3 and 5 → found_nonce=3.
- Abort 5 cycles into range 0..1000 → no pipe_en after the abort cycle; done once all ≤6 issued results return; start during DRAIN ignored.
- Reset asserted mid-ISSUE → all outputs 0 asynchronously; new start works; with MINER_HASHCNT_EN, hash_count=1000 after range 0..999.
